// File: rtl/hash_lookup_pkg.sv
// Shared types, default widths and small helpers for the hash lookup requester.
package hash_lookup_pkg;

  localparam int HLK_KEY_W   = 64;
  localparam int HLK_VAL_W   = 32;
  localparam int HLK_IDX_W   = 8;
  localparam int HLK_TIMEOUT = 15;
  localparam int HLK_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_H_REQ  = 3'd1,
    ST_H_WAIT = 3'd2,
    ST_T_RD   = 3'd3,
    ST_T_CMP  = 3'd4,
    ST_RESP   = 3'd5
  } hlk_state_e;

  typedef logic [HLK_CNT_W-1:0] hlk_cnt_t;

  // Wait counter increment that sticks at all-ones instead of wrapping.
  function automatic hlk_cnt_t hlk_cnt_inc(input hlk_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + hlk_cnt_t'(1);
  endfunction

  // True on the last permitted wait cycle; >= keeps it safe if the count ever overshoots.
  function automatic logic hlk_wait_expired(input hlk_cnt_t cnt, input hlk_cnt_t last);
    return cnt >= last;
  endfunction

endpackage

// File: rtl/hash_lookup_if.sv
// Bundles the parser request, hash unit, table RAM and response signals of the lookup block.
// Signal names keep the lookup block's point of view (_i = into the lookup, _o = out of it).
interface hash_lookup_if
  import hash_lookup_pkg::*;
#(
  parameter int KEY_W = HLK_KEY_W,
  parameter int VAL_W = HLK_VAL_W,
  parameter int IDX_W = HLK_IDX_W
) ();

  logic             req_valid_i;
  logic [KEY_W-1:0] req_key_i;
  logic             req_ready_o;

  logic             hash_start_o;
  logic [KEY_W-1:0] hash_key_o;
  logic             hash_ready_i;
  logic [VAL_W-1:0] hash_val_i;

  logic             tbl_rd_en_o;
  logic [IDX_W-1:0] tbl_addr_o;
  logic             tbl_valid_i;
  logic [KEY_W-1:0] tbl_key_i;
  logic [VAL_W-1:0] tbl_val_i;

  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_hit_o;
  logic             resp_err_o;
  logic [VAL_W-1:0] resp_val_o;

  // The lookup block itself.
  modport master (
    input  req_valid_i, req_key_i,
    output req_ready_o,
    output hash_start_o, hash_key_o,
    input  hash_ready_i, hash_val_i,
    output tbl_rd_en_o, tbl_addr_o,
    input  tbl_valid_i, tbl_key_i, tbl_val_i,
    output resp_valid_o, resp_hit_o, resp_err_o, resp_val_o,
    input  resp_ready_i
  );

  // Everything around it: parser, hash unit, table RAM and match stage.
  modport slave (
    output req_valid_i, req_key_i,
    input  req_ready_o,
    input  hash_start_o, hash_key_o,
    output hash_ready_i, hash_val_i,
    input  tbl_rd_en_o, tbl_addr_o,
    output tbl_valid_i, tbl_key_i, tbl_val_i,
    input  resp_valid_o, resp_hit_o, resp_err_o, resp_val_o,
    output resp_ready_i
  );

endinterface

// File: rtl/hash_lookup.sv
// Requester side of the hash handshake: takes one lookup key at a time, has the hash unit
// compute a table index, reads the exact-match table, compares keys and returns hit/miss
// plus the action word. A hash unit that never answers produces an error response.
module hash_lookup
  import hash_lookup_pkg::*;
#(
  parameter int KEY_W   = HLK_KEY_W,
  parameter int VAL_W   = HLK_VAL_W,
  parameter int IDX_W   = HLK_IDX_W,
  parameter int TIMEOUT = HLK_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  hash_lookup_if.master bus
);

  // Counter value seen on the final H_WAIT cycle, so H_WAIT lasts at most TIMEOUT cycles.
  localparam hlk_cnt_t WAIT_LAST = hlk_cnt_t'(TIMEOUT - 1);

  hlk_state_e       state_q, state_d;
  logic [KEY_W-1:0] key_q,   key_d;
  logic             start_q, start_d;
  hlk_cnt_t         cnt_q,   cnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             hit_q,   hit_d;
  logic             err_q,   err_d;
  logic [VAL_W-1:0] val_q,   val_d;

  // Only the low IDX_W bits of the hash address the table.
  logic unused_hash_hi;
  assign unused_hash_hi = ^bus.hash_val_i[VAL_W-1:IDX_W];

  // State register and datapath flops; reset returns to an idle, all-zero interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

  // Next-state logic: one lookup in flight, walking hash request, table read, compare, response.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    err_d   = err_q;
    val_d   = val_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          key_d   = bus.req_key_i;
          start_d = 1'b1;
          cnt_d   = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          val_d   = '0;
          state_d = ST_H_REQ;
        end
      end

      // hash_ready_i may still be high from the previous operation here, so it is not looked at.
      ST_H_REQ: begin
        state_d = ST_H_WAIT;
      end

      ST_H_WAIT: begin
        cnt_d = hlk_cnt_inc(cnt_q);
        if (bus.hash_ready_i) begin
          idx_d   = bus.hash_val_i[IDX_W-1:0];
          start_d = 1'b0;
          state_d = ST_T_RD;
        end else if (hlk_wait_expired(cnt_q, WAIT_LAST)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          hit_d   = 1'b0;
          val_d   = '0;
          state_d = ST_RESP;
        end
      end

      ST_T_RD: begin
        state_d = ST_T_CMP;
      end

      // Table data arrives one cycle after the read strobe; capture the comparison result now.
      ST_T_CMP: begin
        hit_d   = bus.tbl_valid_i & (bus.tbl_key_i == key_q);
        val_d   = hit_d ? bus.tbl_val_i : '0;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (bus.resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come straight from state and flops, so they stay glitch-free and stable in RESP.
  always_comb begin
    bus.req_ready_o  = (state_q == ST_IDLE);
    bus.hash_start_o = start_q;
    bus.hash_key_o   = key_q;
    bus.tbl_rd_en_o  = (state_q == ST_T_RD);
    bus.tbl_addr_o   = idx_q;
    bus.resp_valid_o = (state_q == ST_RESP);
    bus.resp_hit_o   = hit_q;
    bus.resp_err_o   = err_q;
    bus.resp_val_o   = val_q;
  end

endmodule
